// File: rtl/complex_div_pkg.sv
// rtl/complex_div_pkg.sv - shared widths and state encoding for the complex divider
package complex_div_pkg;

  localparam int CD_AW    = 8;
  localparam int CD_NW    = 16;
  localparam int CD_PW    = CD_NW + CD_AW + 1;
  localparam int CD_ITERS = CD_PW - 1;
  localparam int CD_CW    = $clog2(CD_PW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } cd_state_e;

endpackage

// File: rtl/serial_udiv.sv
// rtl/serial_udiv.sv - unsigned restoring divider, one quotient bit per step, MSB first
module serial_udiv #(
  parameter int DVW = 24,
  parameter int DSW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [DVW-1:0] dividend,
  input  logic [DSW-1:0] divisor,
  output logic [DVW-1:0] quotient
);

  logic [DSW-1:0] rem_q, rem_d;
  logic [DVW-1:0] dq_q;
  logic [DSW-1:0] dsr_q;
  logic [DSW:0]   trial;
  logic           fits;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  // The remainder stays below the divisor, so it never needs more than DSW bits.
  always_comb begin
    trial = {rem_q, dq_q[DVW-1]};
    fits  = (trial >= {1'b0, dsr_q});
    rem_d = fits ? DSW'(trial - {1'b0, dsr_q}) : trial[DSW-1:0];
  end

  // Dividend register doubles as the quotient register as bits shift through it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      dq_q  <= '0;
      dsr_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      dq_q  <= dividend;
      dsr_q <= divisor;
    end else if (step) begin
      rem_q <= rem_d;
      dq_q  <= {dq_q[DVW-2:0], fits};
    end
  end

  assign quotient = dq_q;

endmodule

// File: rtl/complex_div.sv
// rtl/complex_div.sv - sequential complex divider q = n * conj(d) / |d|^2
module complex_div
  import complex_div_pkg::*;
#(
  parameter int AW = CD_AW,
  parameter int NW = CD_NW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] n_re,
  input  logic [NW-1:0] n_im,
  input  logic [AW-1:0] d_re,
  input  logic [AW-1:0] d_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] q_re,
  output logic [AW-1:0] q_im,
  output logic          ovf,
  output logic          dz
);

  localparam int PW    = NW + AW + 1;
  localparam int ITERS = PW - 1;
  localparam int CW    = $clog2(PW);

  localparam logic [AW-1:0] Q_MAX   = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] Q_MIN   = {1'b1, {(AW-1){1'b0}}};
  localparam logic [PW-2:0] MAG_NEG = (PW-1)'(1) << (AW-1);
  localparam logic [PW-2:0] MAG_POS = MAG_NEG - 1'b1;

  cd_state_e state_q;
  logic signed [NW-1:0] n_re_q, n_im_q;
  logic signed [AW-1:0] d_re_q, d_im_q;
  logic                 pr_neg_q, pi_neg_q;
  logic [2*AW-1:0]      den_q;
  logic [CW-1:0]        cnt_q;
  logic                 in_ready_q, out_valid_q, ovf_q, dz_q;
  logic [AW-1:0]        q_re_q, q_im_q;

  logic signed [PW-1:0] n_re_x, n_im_x, d_re_x, d_im_x, pr_c, pi_c;
  logic [AW-1:0]        d_re_abs, d_im_abs;
  logic [2*AW-1:0]      den_c;
  logic [PW-2:0]        pr_abs_c, pi_abs_c, qr_mag, qi_mag;
  logic                 udiv_load, udiv_step;
  logic [AW-1:0]        q_re_d, q_im_d;
  logic                 ovf_re_d, ovf_im_d;

  // Magnitude to signed quotient with clamp; MSB of the result is the saturation flag.
  function automatic logic [AW:0] sat_fn(input logic [PW-2:0] mag, input logic neg);
    if (neg) begin
      if (mag > MAG_NEG) return {1'b1, Q_MIN};
      return {1'b0, AW'(-mag)};
    end
    if (mag > MAG_POS) return {1'b1, Q_MAX};
    return {1'b0, AW'(mag)};
  endfunction

  // Full-precision cross products and |d|^2 from the latched operands; den is built
  // from component magnitudes so -128-128i gives 32768 without wrapping.
  always_comb begin
    n_re_x   = {{(PW-NW){n_re_q[NW-1]}}, n_re_q};
    n_im_x   = {{(PW-NW){n_im_q[NW-1]}}, n_im_q};
    d_re_x   = {{(PW-AW){d_re_q[AW-1]}}, d_re_q};
    d_im_x   = {{(PW-AW){d_im_q[AW-1]}}, d_im_q};
    pr_c     = n_re_x * d_re_x + n_im_x * d_im_x;
    pi_c     = n_im_x * d_re_x - n_re_x * d_im_x;
    d_re_abs = d_re_q[AW-1] ? AW'(-d_re_q) : d_re_q;
    d_im_abs = d_im_q[AW-1] ? AW'(-d_im_q) : d_im_q;
    den_c    = {{AW{1'b0}}, d_re_abs} * {{AW{1'b0}}, d_re_abs}
             + {{AW{1'b0}}, d_im_abs} * {{AW{1'b0}}, d_im_abs};
    pr_abs_c = pr_c[PW-1] ? (PW-1)'(-pr_c) : pr_c[PW-2:0];
    pi_abs_c = pi_c[PW-1] ? (PW-1)'(-pi_c) : pi_c[PW-2:0];
    udiv_load = (state_q == S_PREP);
    udiv_step = (state_q == S_DIV) && (cnt_q != CW'(ITERS));
    {ovf_re_d, q_re_d} = sat_fn(qr_mag, pr_neg_q);
    {ovf_im_d, q_im_d} = sat_fn(qi_mag, pi_neg_q);
  end

  serial_udiv #(.DVW(PW-1), .DSW(2*AW)) u_div_re (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (udiv_load),
    .step     (udiv_step),
    .dividend (pr_abs_c),
    .divisor  (den_c),
    .quotient (qr_mag)
  );

  serial_udiv #(.DVW(PW-1), .DSW(2*AW)) u_div_im (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (udiv_load),
    .step     (udiv_step),
    .dividend (pi_abs_c),
    .divisor  (den_c),
    .quotient (qi_mag)
  );

  // Control FSM: accept, prepare, iterate, finalize and hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_re_q      <= '0;
      n_im_q      <= '0;
      d_re_q      <= '0;
      d_im_q      <= '0;
      pr_neg_q    <= 1'b0;
      pi_neg_q    <= 1'b0;
      den_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_re_q      <= '0;
      q_im_q      <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            n_re_q     <= n_re;
            n_im_q     <= n_im;
            d_re_q     <= d_re;
            d_im_q     <= d_im;
            dz_q       <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= S_PREP;
          end
        end
        S_PREP: begin
          pr_neg_q <= pr_c[PW-1];
          pi_neg_q <= pi_c[PW-1];
          den_q    <= den_c;
          cnt_q    <= '0;
          state_q  <= S_DIV;
        end
        S_DIV: begin
          if (den_q == '0) begin
            q_re_q      <= '0;
            q_im_q      <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (cnt_q == CW'(ITERS)) begin
            q_re_q      <= q_re_d;
            q_im_q      <= q_im_d;
            ovf_q       <= ovf_re_d | ovf_im_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q_re      = q_re_q;
  assign q_im      = q_im_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule
